// File: rtl/mmv_pkg.sv
// Shared sizing helpers and types for the MMV input packer slice.
package mmv_pkg;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    // Always at least one bit so counters that only ever hold 0 stay legal.
    function automatic int unsigned mmv_clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned mmv_fold(input int unsigned channels, input int unsigned simd);
        return channels / simd;
    endfunction

    function automatic int unsigned mmv_groups(input int unsigned width, input int unsigned lanes);
        return (width + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/mmv_pack_bank.sv
// One ping-pong bank: word storage, full flag and the per-fold lane read mux.
module mmv_pack_bank
    import mmv_pkg::*;
#(
    parameter int unsigned LANES = 3,
    parameter int unsigned FOLD  = 2,
    parameter int unsigned WW    = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned FW    = 1
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  we_i,
    input  logic                  first_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [WW-1:0]         wdata_i,
    input  logic                  set_full_i,
    input  logic                  clr_full_i,
    input  logic [FW-1:0]         rfold_i,
    output logic                  full_o,
    output logic [LANES*WW-1:0]   rdata_o
);

    localparam int unsigned DEPTH = LANES * FOLD;

    logic [WW-1:0] mem_q [DEPTH];
    logic          full_q, full_d;

    // The first word of a group wipes the bank so lanes a short group never writes read as zero.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (first_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        full_d = full_q;
        if (clr_full_i) full_d = 1'b0;
        if (set_full_i) full_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) full_q <= 1'b0;
        else           full_q <= full_d;
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            rdata_o[k*WW +: WW] = mem_q[AW'(k * FOLD) + AW'(rfold_i)];
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/mmv_input_packer.sv
// Packs a FINN-order pixel/fold stream into MMV_IN-lane beats via two ping-pong banks.
// Optional op_axis_tlast output is enabled by defining MMV_INPUT_PACKER_TLAST_EN.
module mmv_input_packer
    import mmv_pkg::*;
#(
    parameter int unsigned MMV_IN       = 3,
    parameter int unsigned SIMD         = 1,
    parameter int unsigned IP_PRECISION = 8,
    parameter int unsigned IFMChannels  = 2,
    parameter int unsigned IFMWidth     = 6,
    parameter int unsigned IFMHeight    = 6
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [SIMD*IP_PRECISION-1:0]          ip_axis_tdata,
    input  logic                                  ip_axis_tvalid,
    output logic                                  ip_axis_tready,
    output logic [MMV_IN*SIMD*IP_PRECISION-1:0]   op_axis_tdata,
    output logic                                  op_axis_tvalid,
    input  logic                                  op_axis_tready
`ifdef MMV_INPUT_PACKER_TLAST_EN
   ,output logic                                  op_axis_tlast
`endif
);

    localparam int unsigned FOLD       = mmv_fold(IFMChannels, SIMD);
    localparam int unsigned NGRP       = mmv_groups(IFMWidth, MMV_IN);
    localparam int unsigned LAST_LANES = IFMWidth - (NGRP - 1) * MMV_IN;
    localparam int unsigned WW         = SIMD * IP_PRECISION;
    localparam int unsigned OW         = MMV_IN * WW;
    localparam int unsigned FW         = mmv_clog2(FOLD);
    localparam int unsigned CW         = mmv_clog2(MMV_IN);
    localparam int unsigned GW         = mmv_clog2(NGRP);
    localparam int unsigned RW         = mmv_clog2(IFMHeight);
    localparam int unsigned AW         = mmv_clog2(MMV_IN * FOLD);

    logic [FW-1:0] fold_q, fold_d, rd_fold_q, rd_fold_d;
    logic [CW-1:0] col_q, col_d, grp_last_col;
    logic [GW-1:0] grp_q, grp_d;
    logic [RW-1:0] row_q, row_d;
    bank_e         wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;

    logic          full0, full1, wr_full, rd_full;
    logic [OW-1:0] rdata0, rdata1;
    logic          accept, emit, fold_last, last_grp, grp_done, first, beat_last, frame_end;
    logic [AW-1:0] waddr;

    always_comb begin
        wr_full      = (wr_bank_q == BANK0) ? full0 : full1;
        rd_full      = (rd_bank_q == BANK0) ? full0 : full1;
        accept       = ip_axis_tvalid && !wr_full;
        emit         = rd_full && op_axis_tready;
        last_grp     = grp_q == GW'(NGRP - 1);
        grp_last_col = last_grp ? CW'(LAST_LANES - 1) : CW'(MMV_IN - 1);
        fold_last    = fold_q == FW'(FOLD - 1);
        grp_done     = accept && fold_last && (col_q == grp_last_col);
        frame_end    = last_grp && (row_q == RW'(IFMHeight - 1));
        first        = (col_q == '0) && (fold_q == '0);
        waddr        = AW'(col_q) * AW'(FOLD) + AW'(fold_q);
        beat_last    = rd_fold_q == FW'(FOLD - 1);
    end

    always_comb begin
        fold_d    = fold_q;
        col_d     = col_q;
        grp_d     = grp_q;
        row_d     = row_q;
        wr_bank_d = wr_bank_q;
        rd_fold_d = rd_fold_q;
        rd_bank_d = rd_bank_q;
        if (accept) begin
            if (!fold_last) begin
                fold_d = fold_q + 1'b1;
            end else begin
                fold_d = '0;
                if (col_q != grp_last_col) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d     = '0;
                    wr_bank_d = (wr_bank_q == BANK0) ? BANK1 : BANK0;
                    if (!last_grp) begin
                        grp_d = grp_q + 1'b1;
                    end else begin
                        grp_d = '0;
                        row_d = (row_q == RW'(IFMHeight - 1)) ? '0 : row_q + 1'b1;
                    end
                end
            end
        end
        if (emit) begin
            if (beat_last) begin
                rd_fold_d = '0;
                rd_bank_d = (rd_bank_q == BANK0) ? BANK1 : BANK0;
            end else begin
                rd_fold_d = rd_fold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fold_q    <= '0;
            col_q     <= '0;
            grp_q     <= '0;
            row_q     <= '0;
            wr_bank_q <= BANK0;
            rd_fold_q <= '0;
            rd_bank_q <= BANK0;
        end else begin
            fold_q    <= fold_d;
            col_q     <= col_d;
            grp_q     <= grp_d;
            row_q     <= row_d;
            wr_bank_q <= wr_bank_d;
            rd_fold_q <= rd_fold_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    mmv_pack_bank #(.LANES(MMV_IN), .FOLD(FOLD), .WW(WW), .AW(AW), .FW(FW)) u_bank0 (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .we_i       (accept && (wr_bank_q == BANK0)),
        .first_i    (first),
        .waddr_i    (waddr),
        .wdata_i    (ip_axis_tdata),
        .set_full_i (grp_done && (wr_bank_q == BANK0)),
        .clr_full_i (emit && beat_last && (rd_bank_q == BANK0)),
        .rfold_i    (rd_fold_q),
        .full_o     (full0),
        .rdata_o    (rdata0)
    );

    mmv_pack_bank #(.LANES(MMV_IN), .FOLD(FOLD), .WW(WW), .AW(AW), .FW(FW)) u_bank1 (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .we_i       (accept && (wr_bank_q == BANK1)),
        .first_i    (first),
        .waddr_i    (waddr),
        .wdata_i    (ip_axis_tdata),
        .set_full_i (grp_done && (wr_bank_q == BANK1)),
        .clr_full_i (emit && beat_last && (rd_bank_q == BANK1)),
        .rfold_i    (rd_fold_q),
        .full_o     (full1),
        .rdata_o    (rdata1)
    );

    assign ip_axis_tready = !wr_full;
    assign op_axis_tvalid = rd_full;
    assign op_axis_tdata  = (rd_bank_q == BANK0) ? rdata0 : rdata1;

`ifdef MMV_INPUT_PACKER_TLAST_EN
    // Each bank remembers whether the group it holds closes a frame.
    logic [1:0] tag_q, tag_d;

    always_comb begin
        tag_d = tag_q;
        if (grp_done) begin
            if (wr_bank_q == BANK0) tag_d[0] = frame_end;
            else                    tag_d[1] = frame_end;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tag_q <= '0;
        else         tag_q <= tag_d;
    end

    assign op_axis_tlast = rd_full && beat_last && ((rd_bank_q == BANK0) ? tag_q[0] : tag_q[1]);
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_mmv_input_packer.sv
// Self-checking bench: default-size packer (dut_a) plus a short-row variant (dut_b, IFMWidth=5).
module tb_mmv_input_packer;

    localparam int unsigned W = 6;
    localparam int unsigned H = 6;
    localparam int unsigned FOLDN = 2;
    localparam int unsigned LANES = 3;
    localparam int unsigned NG = (W + LANES - 1) / LANES;
    localparam int unsigned BEATS_PER_FRAME = H * NG * FOLDN;
    localparam int unsigned WORDS_PER_FRAME = H * W * FOLDN;

    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic [7:0]  a_tdata;
    logic        a_tvalid, a_tready;
    logic [23:0] a_odata;
    logic        a_ovalid, a_oready;
    logic [7:0]  b_tdata;
    logic        b_tvalid, b_tready;
    logic [23:0] b_odata;
    logic        b_ovalid, b_oready;
`ifdef MMV_INPUT_PACKER_TLAST_EN
    logic        a_otlast, b_otlast;
`endif

    logic [7:0] acc_q[$];

    mmv_input_packer #(.MMV_IN(3), .SIMD(1), .IP_PRECISION(8), .IFMChannels(2),
                       .IFMWidth(6), .IFMHeight(6)) dut_a (
        .clk(clk), .resetn(resetn),
        .ip_axis_tdata(a_tdata), .ip_axis_tvalid(a_tvalid), .ip_axis_tready(a_tready),
        .op_axis_tdata(a_odata), .op_axis_tvalid(a_ovalid), .op_axis_tready(a_oready)
`ifdef MMV_INPUT_PACKER_TLAST_EN
       ,.op_axis_tlast(a_otlast)
`endif
    );

    mmv_input_packer #(.MMV_IN(3), .SIMD(1), .IP_PRECISION(8), .IFMChannels(2),
                       .IFMWidth(5), .IFMHeight(6)) dut_b (
        .clk(clk), .resetn(resetn),
        .ip_axis_tdata(b_tdata), .ip_axis_tvalid(b_tvalid), .ip_axis_tready(b_tready),
        .op_axis_tdata(b_odata), .op_axis_tvalid(b_ovalid), .op_axis_tready(b_oready)
`ifdef MMV_INPUT_PACKER_TLAST_EN
       ,.op_axis_tlast(b_otlast)
`endif
    );

    // Reference: beat n of the output stream, derived from the accepted word stream.
    function automatic logic [23:0] exp_beat(input int unsigned n);
        int unsigned frame, r, row, grp, f, col, idx;
        logic [23:0] b;
        frame = n / BEATS_PER_FRAME;
        r     = n % BEATS_PER_FRAME;
        row   = r / (NG * FOLDN);
        grp   = (r / FOLDN) % NG;
        f     = r % FOLDN;
        b     = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            col = grp * LANES + k;
            idx = frame * WORDS_PER_FRAME + (row * W + col) * FOLDN + f;
            if (col < W && idx < acc_q.size()) b[k*8 +: 8] = acc_q[idx];
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        a_tvalid = 1'b0; a_tdata = '0; a_oready = 1'b0;
        b_tvalid = 1'b0; b_tdata = '0; b_oready = 1'b0;
        acc_q.delete();
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic push_a(input logic [7:0] w);
        int unsigned n;
        n = 0;
        a_tdata = w;
        a_tvalid = 1'b1;
        while (a_tready !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (a_tready !== 1'b1) begin
            failures++;
            $display("FAIL push_a_wait word=%h tready=%b required 1", w, a_tready);
        end
        step();
        a_tvalid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] w);
        int unsigned n;
        n = 0;
        b_tdata = w;
        b_tvalid = 1'b1;
        while (b_tready !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (b_tready !== 1'b1) begin
            failures++;
            $display("FAIL push_b_wait word=%h tready=%b required 1", w, b_tready);
        end
        step();
        b_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_tready !== 1'b1) begin failures++; $display("FAIL reset_a_tready got=%b exp=1", a_tready); end
        checks++;
        if (a_ovalid !== 1'b0) begin failures++; $display("FAIL reset_a_ovalid got=%b exp=0", a_ovalid); end
        checks++;
        if (b_tready !== 1'b1) begin failures++; $display("FAIL reset_b_tready got=%b exp=1", b_tready); end
        checks++;
        if (b_ovalid !== 1'b0) begin failures++; $display("FAIL reset_b_ovalid got=%b exp=0", b_ovalid); end
`ifdef MMV_INPUT_PACKER_TLAST_EN
        checks++;
        if (a_otlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", a_otlast); end
`endif
    endtask

    task automatic test_group0();
        do_reset();
        for (int i = 1; i <= 5; i++) push_a(8'(i));
        checks++;
        if (a_ovalid !== 1'b0) begin failures++; $display("FAIL g0_early_valid got=%b exp=0", a_ovalid); end
        push_a(8'h06);
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 24'h050301) begin
            failures++; $display("FAIL g0_beat0 valid=%b data=%h exp valid=1 data=050301", a_ovalid, a_odata);
        end
        a_oready = 1'b1;
        step();
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 24'h060402) begin
            failures++; $display("FAIL g0_beat1 valid=%b data=%h exp valid=1 data=060402", a_ovalid, a_odata);
        end
`ifdef MMV_INPUT_PACKER_TLAST_EN
        checks++;
        if (a_otlast !== 1'b0) begin failures++; $display("FAIL g0_tlast got=%b exp=0", a_otlast); end
`endif
        step();
        checks++;
        if (a_ovalid !== 1'b0) begin failures++; $display("FAIL g0_drain got=%b exp=0", a_ovalid); end
        a_oready = 1'b0;
    endtask

    task automatic test_short_row();
        logic [23:0] exp_b [4];
        exp_b[0] = 24'h050301; exp_b[1] = 24'h060402;
        exp_b[2] = 24'h000907; exp_b[3] = 24'h000A08;
        do_reset();
        for (int i = 1; i <= 10; i++) push_b(8'(i));
        b_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_ovalid !== 1'b1 || b_odata !== exp_b[i]) begin
                failures++;
                $display("FAIL short_row_beat%0d valid=%b data=%h exp valid=1 data=%h", i, b_ovalid, b_odata, exp_b[i]);
            end
            step();
        end
        checks++;
        if (b_ovalid !== 1'b0 || b_tready !== 1'b1) begin
            failures++; $display("FAIL short_row_idle valid=%b tready=%b exp valid=0 tready=1", b_ovalid, b_tready);
        end
        b_oready = 1'b0;
    endtask

    task automatic test_backpressure();
        int unsigned acc, word, hold_bad;
        do_reset();
        acc = 0; word = 1; hold_bad = 0;
        a_tvalid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            a_tdata = 8'(word);
            if (a_ovalid === 1'b1 && a_odata !== 24'h050301) hold_bad++;
            if (a_tready === 1'b1) begin acc++; word++; end
            step();
        end
        a_tvalid = 1'b0;
        checks++;
        if (acc != 12) begin failures++; $display("FAIL bp_accepted got=%0d exp=12", acc); end
        checks++;
        if (a_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", a_tready); end
        checks++;
        if (hold_bad != 0) begin failures++; $display("FAIL bp_hold changed_cycles=%0d exp=0", hold_bad); end
        a_oready = 1'b1;
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 24'h050301) begin
            failures++; $display("FAIL bp_beat0 valid=%b data=%h exp valid=1 data=050301", a_ovalid, a_odata);
        end
        step();
        checks++;
        if (a_odata !== 24'h060402) begin failures++; $display("FAIL bp_beat1 data=%h exp=060402", a_odata); end
        step();
        checks++;
        if (a_odata !== 24'h0B0907 || a_tready !== 1'b1) begin
            failures++; $display("FAIL bp_beat2 data=%h tready=%b exp data=0B0907 tready=1", a_odata, a_tready);
        end
        step();
        checks++;
        if (a_odata !== 24'h0C0A08) begin failures++; $display("FAIL bp_beat3 data=%h exp=0C0A08", a_odata); end
        a_oready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) push_a(8'(i));
        resetn = 1'b0;
        #2;
        checks++;
        if (a_tready !== 1'b1 || a_ovalid !== 1'b0) begin
            failures++; $display("FAIL rst_async tready=%b valid=%b exp tready=1 valid=0", a_tready, a_ovalid);
        end
        step();
        resetn = 1'b1;
        step();
        for (int i = 0; i < 6; i++) push_a(8'(8'h10 + i));
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 24'h141210) begin
            failures++; $display("FAIL rst_beat0 valid=%b data=%h exp valid=1 data=141210", a_ovalid, a_odata);
        end
        a_oready = 1'b1;
        step();
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 24'h151311) begin
            failures++; $display("FAIL rst_beat1 valid=%b data=%h exp valid=1 data=151311", a_ovalid, a_odata);
        end
        step();
        checks++;
        if (a_ovalid !== 1'b0) begin failures++; $display("FAIL rst_drain got=%b exp=0", a_ovalid); end
        a_oready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned sent, beats, drops, bad;
        logic acc;
        logic [23:0] e;
        do_reset();
        sent = 0; beats = 0; drops = 0; bad = 0;
        a_oready = 1'b1;
        for (int c = 0; c < 600 && beats < 2 * BEATS_PER_FRAME; c++) begin
            if (sent < 2 * WORDS_PER_FRAME) begin
                a_tvalid = 1'b1;
                a_tdata  = (sent < WORDS_PER_FRAME) ? 8'(sent + 1) : 8'($urandom);
            end else begin
                a_tvalid = 1'b0;
            end
            if (a_ovalid === 1'b1) begin
                e = exp_beat(beats);
                checks++;
                if (a_odata !== e) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL b2b_beat%0d data=%h exp=%h", beats, a_odata, e);
                end
`ifdef MMV_INPUT_PACKER_TLAST_EN
                checks++;
                if (a_otlast !== ((beats % BEATS_PER_FRAME) == BEATS_PER_FRAME - 1)) begin
                    failures++; $display("FAIL b2b_tlast beat=%0d got=%b", beats, a_otlast);
                end
`endif
                beats++;
            end
            if (a_tvalid && a_tready !== 1'b1 && sent >= LANES * FOLDN) drops++;
            acc = a_tvalid && (a_tready === 1'b1);
            step();
            if (acc) begin acc_q.push_back(a_tdata); sent++; end
        end
        a_tvalid = 1'b0;
        checks++;
        if (beats != 2 * BEATS_PER_FRAME) begin failures++; $display("FAIL b2b_beats got=%0d exp=%0d", beats, 2 * BEATS_PER_FRAME); end
        checks++;
        if (sent != 2 * WORDS_PER_FRAME) begin failures++; $display("FAIL b2b_words got=%0d exp=%0d", sent, 2 * WORDS_PER_FRAME); end
        checks++;
        if (drops != 0) begin failures++; $display("FAIL b2b_tready_drops got=%0d exp=0", drops); end
        checks++;
        if (a_ovalid !== 1'b0) begin failures++; $display("FAIL b2b_idle valid=%b exp=0", a_ovalid); end
        a_oready = 1'b0;
    endtask

    task automatic test_random();
        int unsigned sent, beats, bad;
        logic acc, stalled;
        logic [23:0] e, prev;
        do_reset();
        sent = 0; beats = 0; bad = 0; stalled = 1'b0; prev = '0;
        for (int c = 0; c < 4000 && beats < 2 * BEATS_PER_FRAME; c++) begin
            a_oready = ($urandom_range(0, 2) != 0);
            if (sent < 2 * WORDS_PER_FRAME && $urandom_range(0, 3) != 0) begin
                a_tvalid = 1'b1;
                a_tdata  = 8'($urandom);
            end else begin
                a_tvalid = 1'b0;
            end
            if (stalled) begin
                checks++;
                if (a_ovalid !== 1'b1 || a_odata !== prev) begin
                    failures++; $display("FAIL rnd_hold valid=%b data=%h exp valid=1 data=%h", a_ovalid, a_odata, prev);
                end
            end
            if (a_ovalid === 1'b1 && a_oready) begin
                e = exp_beat(beats);
                checks++;
                if (a_odata !== e) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL rnd_beat%0d data=%h exp=%h", beats, a_odata, e);
                end
`ifdef MMV_INPUT_PACKER_TLAST_EN
                checks++;
                if (a_otlast !== ((beats % BEATS_PER_FRAME) == BEATS_PER_FRAME - 1)) begin
                    failures++; $display("FAIL rnd_tlast beat=%0d got=%b", beats, a_otlast);
                end
`endif
                beats++;
            end
            stalled = (a_ovalid === 1'b1) && !a_oready;
            prev    = a_odata;
            acc     = a_tvalid && (a_tready === 1'b1);
            step();
            if (acc) begin acc_q.push_back(a_tdata); sent++; end
        end
        a_tvalid = 1'b0;
        a_oready = 1'b0;
        checks++;
        if (beats != 2 * BEATS_PER_FRAME) begin failures++; $display("FAIL rnd_beats got=%0d exp=%0d", beats, 2 * BEATS_PER_FRAME); end
    endtask

    initial begin
        test_reset();
        test_group0();
        test_short_row();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmv_input_packer.md
MMV_INPUT_PACKER -- requirements
Module: mmv_input_packer

Interface
REQ-001 SHALL have parameter MMV_IN, default 3: pixel lanes per output beat.
REQ-002 SHALL have parameter SIMD, default 1: channels per input word.
REQ-003 SHALL have parameter IP_PRECISION, default 8: bits per channel.
REQ-004 SHALL have parameter IFMChannels, default 2: channels per pixel (multiple of SIMD); FOLD = IFMChannels/SIMD.
REQ-005 SHALL have parameter IFMWidth, default 6: pixels per row (any value >= 1).
REQ-006 SHALL have parameter IFMHeight, default 6: rows per frame.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port ip_axis_tdata, input, SIMD*IP_PRECISION: one channel fold of one pixel, FINN order (row, col, fold).
REQ-010 SHALL have port ip_axis_tvalid, input, 1; port ip_axis_tready, output, 1.
REQ-011 SHALL have port op_axis_tdata, output, MMV_IN*SIMD*IP_PRECISION: lane k at bits [k*SIMD*IP_PRECISION +: SIMD*IP_PRECISION].
REQ-012 SHALL have port op_axis_tvalid, output, 1; port op_axis_tready, input, 1.

Function
REQ-013 SHALL convert the narrow pixel stream into the MMV_IN-wide stream consumed by mmv_input_swu: each row is split into column groups of MMV_IN; per group, FOLD output beats are emitted, fold f in order 0..FOLD-1.
REQ-014 SHALL place pixel column g*MMV_IN+k, fold f, into lane k of output beat f of group g.
REQ-015 SHALL, when IFMWidth mod MMV_IN != 0, end the last group of each row early and drive unused lanes to zero; groups never span rows.
REQ-016 SHALL buffer via two banks (ping-pong) of MMV_IN*FOLD words each; the write address of a word is col_in_group*FOLD+fold.
REQ-017 SHALL set the write bank's full flag on the edge that accepts the group's last word, then toggle the write bank.
REQ-018 SHALL drive ip_axis_tready = NOT full[write bank]; a transfer occurs when tvalid and tready are both high at the rising edge.
REQ-019 SHALL drive op_axis_tvalid = full[read bank], with data muxed from registered bank contents; first output beat is valid the cycle after the accepting edge (latency 1).
REQ-020 SHALL, on the output handshake of beat FOLD-1, clear full[read bank] and toggle the read bank.
REQ-021 SHALL hold op_axis_tdata stable while op_axis_tvalid=1 and op_axis_tready=0.
REQ-022 SHALL allow a write into one bank and a read/clear of the other in the same cycle; a bank cleared on an edge SHALL accept a write from the next cycle.
REQ-023 SHALL wrap fold, column and row counters; after row IFMHeight-1 the next word starts row 0 of a new frame.

Reset
REQ-024 SHALL, while resetn=0, asynchronously clear both full flags, both bank pointers and all counters; ip_axis_tready=1 and op_axis_tvalid=0 from the first edge after release.
REQ-025 SHALL discard any partial or unsent group when reset asserts mid-frame; bank data need not be cleared.

Configuration
REQ-026 SHALL, with macro MMV_INPUT_PACKER_TLAST_EN defined, add output port op_axis_tlast (1 bit), high on beat FOLD-1 of the last group of row IFMHeight-1, else low; reset value 0.
REQ-027 SHALL, without MMV_INPUT_PACKER_TLAST_EN, omit op_axis_tlast and all of its logic.

Structure
REQ-028 SHALL take FOLD, group-count-per-row and counter-width localparams and a clog2 helper from shared package mmv_pkg.
REQ-029 SHALL implement each storage bank as sub-module mmv_pack_bank (write port, full flag, MMV_IN-lane fold read mux), instantiated twice.

Verification (defaults; input words 0x01,0x02,... in sequence)
REQ-030 SHALL check group 0: op_axis_tready=1 -> beats 24'h050301, then 24'h060402, the first valid 1 cycle after word 0x06 is accepted.
REQ-031 SHALL check a short row with IFMWidth=5: group 1 of row 0 -> beats 24'h000907, then 24'h000A08.
REQ-032 SHALL check backpressure: with op_axis_tready=0, exactly 12 words are accepted, after which ip_axis_tready=0; tdata=24'h050301 holds until tready rises.
REQ-033 SHALL check concurrency: with both valids held high, one word is accepted per cycle with no ip_axis_tready drop after the first group; 72 words in -> 24 beats out per frame.
REQ-034 SHALL check reset mid-group: resetn pulsed low after word 0x04 -> no output; the next six words 0x10..0x15 yield 24'h141210 and 24'h151311.
REQ-035 SHALL check, with MMV_INPUT_PACKER_TLAST_EN, that op_axis_tlast=1 only on beat 24 of each frame.
